// File: rtl/muldiv_seq_if.sv
// Request/response bundle between the EX stage and the RV32M sequencer.
// The EX side owns the request fields; the sequencer drives status and result.
interface muldiv_seq_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            flush;
  logic            busy;
  logic            stall;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, funct3, rs1, rs2, flush,
    input  busy, stall, done, result
  );

  modport slave (
    input  start, funct3, rs1, rs2, flush,
    output busy, stall, done, result
  );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add and restoring divide
// on operand magnitudes, with the sign applied once in the FIX state.
module muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic       clk,
  input  logic       rst,
  muldiv_seq_if.slave bus
);
  localparam int CW = $clog2(XLEN);

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_CALC, S_FIX, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     count_q, count_d;
  logic [2:0]        op_q, op_d;
  logic [XLEN-1:0]   a_q, a_d, b_q, b_d;
  logic [XLEN-1:0]   mcand_q, mcand_d;
  logic [2*XLEN-1:0] prod_q, prod_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   result_q, result_d;

  // Operand signs and magnitudes, only meaningful while in PREP.
  logic            sign_a, sign_b, is_div, is_rem, div_zero, div_ovf, fast;
  logic [XLEN-1:0] mag_a, mag_b, fast_val;

  assign is_div   = op_q[2];
  assign is_rem   = op_q[2] & op_q[1];
  assign sign_a   = a_q[XLEN-1] & (op_q == 3'b001 || op_q == 3'b010 ||
                                   op_q == 3'b100 || op_q == 3'b110);
  assign sign_b   = b_q[XLEN-1] & (op_q == 3'b001 || op_q == 3'b100 || op_q == 3'b110);
  assign mag_a    = sign_a ? -a_q : a_q;
  assign mag_b    = sign_b ? -b_q : b_q;
  assign div_zero = is_div && (b_q == '0);
  assign div_ovf  = (op_q == 3'b100 || op_q == 3'b110) &&
                    (a_q == {1'b1, {(XLEN-1){1'b0}}}) && (b_q == '1);
  assign fast     = div_zero || div_ovf;
  // Overflow DIV returns the dividend itself (0x80000000); REM returns 0.
  assign fast_val = div_zero ? (op_q[1] ? a_q : '1) : (op_q[1] ? '0 : a_q);

  // One iteration of each datapath; the XLEN+1 bit forms expose carry/borrow.
  logic [XLEN:0]     mul_sum, div_shift, div_trial;
  assign mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} +
                     (prod_q[0] ? {1'b0, mcand_q} : {(XLEN+1){1'b0}});
  assign div_shift = {rem_q, prod_q[XLEN-1]};
  assign div_trial = div_shift - {1'b0, mcand_q};

  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   rem_fix;
  assign prod_fix = neg_q ? -prod_q : prod_q;
  assign rem_fix  = neg_q ? -rem_q  : rem_q;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    mcand_d  = mcand_q;
    prod_d   = prod_q;
    rem_d    = rem_q;
    neg_d    = neg_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.flush) begin
          op_d    = bus.funct3;
          a_d     = bus.rs1;
          b_d     = bus.rs2;
          state_d = S_PREP;
        end
      end
      S_PREP: begin
        if (fast) begin
          result_d = fast_val;
          state_d  = S_DONE;
        end else begin
          count_d = '0;
          mcand_d = is_div ? mag_b : mag_a;
          prod_d  = {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
          rem_d   = '0;
          neg_d   = is_rem ? sign_a : (sign_a ^ sign_b);
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        if (is_div) begin
          rem_d               = div_trial[XLEN] ? div_shift[XLEN-1:0] : div_trial[XLEN-1:0];
          prod_d[XLEN-1:0]    = {prod_q[XLEN-2:0], ~div_trial[XLEN]};
        end else begin
          prod_d = {mul_sum, prod_q[XLEN-1:1]};
        end
        count_d = count_q + CW'(1);
        if (count_q == CW'(XLEN-1)) state_d = S_FIX;
      end
      S_FIX: begin
        case (op_q)
          3'b000:                 result_d = prod_fix[XLEN-1:0];
          3'b001, 3'b010, 3'b011: result_d = prod_fix[2*XLEN-1:XLEN];
          3'b100, 3'b101:         result_d = prod_fix[XLEN-1:0];
          default:                result_d = rem_fix;
        endcase
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
    // An abort discards the operation without touching the visible result.
    if (bus.flush && state_q != S_IDLE) begin
      state_d  = S_IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      mcand_q  <= '0;
      prod_q   <= '0;
      rem_q    <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      mcand_q  <= mcand_d;
      prod_q   <= prod_d;
      rem_q    <= rem_d;
      neg_q    <= neg_d;
      result_q <= result_d;
    end
  end

  assign bus.busy   = (state_q != S_IDLE);
  assign bus.done   = (state_q == S_DONE);
  assign bus.stall  = (state_q == S_IDLE && bus.start) ||
                      state_q == S_PREP || state_q == S_CALC || state_q == S_FIX;
  assign bus.result = result_q;
endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: directed vector table, randomized ops against an
// arithmetic reference model, plus flush / ignored-start / async-reset sequences.
module tb_muldiv_seq;
  logic clk;
  logic rst;
  muldiv_seq_if #(.XLEN(32)) ifc ();

  muldiv_seq #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", nm, got, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic straight from the RV32M definitions.
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                        input logic [31:0] b);
    longint      sa, sb, q;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (f)
      3'b000: begin p = {32'd0, a} * {32'd0, b}; return p[31:0];  end
      3'b001: begin p = sa * sb;                 return p[63:32]; end
      3'b010: begin p = sa * longint'({32'd0, b}); return p[63:32]; end
      3'b011: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'b100: begin if (b == 0) return 32'hFFFFFFFF; q = sa / sb; return q[31:0]; end
      3'b101: begin if (b == 0) return 32'hFFFFFFFF; return a / b; end
      3'b110: begin if (b == 0) return a; q = sa % sb; return q[31:0]; end
      default: begin if (b == 0) return a; return a % b; end
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] f, input logic [31:0] a,
                                   input logic [31:0] b);
    if (f[2] && b == 0) return 1;
    if ((f == 3'b100 || f == 3'b110) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
    return 34;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h80000000;
      2:       return 32'hFFFFFFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Caller is at #1 after an edge with the unit idle. Returns at #1 after the
  // cycle following done.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int exp_lat);
    int   lat;
    logic stall_ok;
    logic [31:0] res;
    ifc.start  = 1'b1;
    ifc.funct3 = f;
    ifc.rs1    = a;
    ifc.rs2    = b;
    #1;
    chk("stall_on_start", 32'(ifc.stall), 32'd1);
    @(posedge clk); #1;
    ifc.start = 1'b0;
    ifc.rs1   = $urandom;
    ifc.rs2   = $urandom;
    lat      = 0;
    stall_ok = 1'b1;
    while (!ifc.done && lat < 60) begin
      if (ifc.stall !== 1'b1) stall_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    res = ifc.result;
    chk("stall_while_busy", 32'(stall_ok), 32'd1);
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("result", res, exp);
    chk("stall_at_done", 32'(ifc.stall), 32'd0);
    @(posedge clk); #1;
    chk("done_one_cycle", 32'(ifc.done), 32'd0);
    chk("busy_after_done", 32'(ifc.busy), 32'd0);
    $display("op f3=%0d rs1=%h rs2=%h -> result=%h (exp %h) latency=%0d", f, a, b, res, exp, lat);
  endtask

  initial begin
    logic [2:0]  f;
    logic [31:0] a, b, prev;
    int          lat;
    logic        saw_done;

    tbl[0]  = '{3'b100, 32'd20,         32'hFFFFFFFD, 32'hFFFFFFFA, 34};
    tbl[1]  = '{3'b110, 32'hFFFFFFEC,   32'd3,        32'hFFFFFFFE, 34};
    tbl[2]  = '{3'b111, 32'hFFFFFFEC,   32'd3,        32'h00000002, 34};
    tbl[3]  = '{3'b101, 32'hFFFFFFEC,   32'd3,        32'h5555554E, 34};
    tbl[4]  = '{3'b101, 32'h12345678,   32'd0,        32'hFFFFFFFF, 1};
    tbl[5]  = '{3'b110, 32'd7,          32'd0,        32'd7,        1};
    tbl[6]  = '{3'b100, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 1};
    tbl[7]  = '{3'b110, 32'h80000000,   32'hFFFFFFFF, 32'h00000000, 1};
    tbl[8]  = '{3'b001, 32'h80000000,   32'h80000000, 32'h40000000, 34};
    tbl[9]  = '{3'b000, 32'h80000000,   32'h80000000, 32'h00000000, 34};
    tbl[10] = '{3'b011, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE, 34};
    tbl[11] = '{3'b000, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'h00000001, 34};
    tbl[12] = '{3'b010, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFF, 34};
    tbl[13] = '{3'b100, 32'd7,          32'd0,        32'hFFFFFFFF, 1};
    tbl[14] = '{3'b111, 32'd5,          32'd0,        32'd5,        1};
    tbl[15] = '{3'b100, 32'h80000000,   32'd1,        32'h80000000, 34};

    rst        = 1'b1;
    ifc.start  = 1'b0;
    ifc.flush  = 1'b0;
    ifc.funct3 = 3'b000;
    ifc.rs1    = 32'd0;
    ifc.rs2    = 32'd0;
    #12;
    chk("reset_busy",   32'(ifc.busy),  32'd0);
    chk("reset_stall",  32'(ifc.stall), 32'd0);
    chk("reset_done",   32'(ifc.done),  32'd0);
    chk("reset_result", ifc.result,     32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++)
      run_op(tbl[i].f, tbl[i].a, tbl[i].b, tbl[i].exp, tbl[i].lat);

    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom_range(0, 7));
      a = pick();
      b = pick();
      run_op(f, a, b, model(f, a, b), model_lat(f, a, b));
    end

    // Flush at count = 10: result must keep the previous op's value.
    prev = model(3'b000, 32'd1234, 32'd5678);
    run_op(3'b000, 32'd1234, 32'd5678, prev, 34);
    ifc.start = 1'b1; ifc.funct3 = 3'b011; ifc.rs1 = 32'hDEADBEEF; ifc.rs2 = 32'h12345;
    @(posedge clk); #1;
    ifc.start = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    ifc.flush = 1'b1;
    @(posedge clk); #1;
    ifc.flush = 1'b0;
    chk("flush_busy", 32'(ifc.busy), 32'd0);
    saw_done = ifc.done;
    repeat (40) begin
      @(posedge clk); #1;
      if (ifc.done) saw_done = 1'b1;
    end
    chk("flush_no_done", 32'(saw_done), 32'd0);
    chk("flush_result_held", ifc.result, prev);
    $display("flush at count 10: busy=%0d done_seen=%0d result=%h", ifc.busy, saw_done, ifc.result);

    // Flush together with start in IDLE: the start is not taken.
    ifc.start = 1'b1; ifc.flush = 1'b1; ifc.funct3 = 3'b100;
    @(posedge clk); #1;
    ifc.start = 1'b0; ifc.flush = 1'b0;
    chk("flush_blocks_start", 32'(ifc.busy), 32'd0);
    $display("flush+start in idle: busy=%0d", ifc.busy);

    // start pulsed mid-CALC with other operands must be ignored.
    a = 32'hFFFFF000; b = 32'd37;
    ifc.start = 1'b1; ifc.funct3 = 3'b100; ifc.rs1 = a; ifc.rs2 = b;
    @(posedge clk); #1;
    ifc.start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    ifc.start = 1'b1; ifc.funct3 = 3'b000; ifc.rs1 = 32'd3; ifc.rs2 = 32'd4;
    @(posedge clk); #1;
    ifc.start = 1'b0;
    lat = 6;
    while (!ifc.done && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("ignored_start_latency", 32'(lat), 32'd34);
    chk("ignored_start_result", ifc.result, model(3'b100, a, b));
    $display("start during CALC ignored: result=%h latency=%0d", ifc.result, lat);
    @(posedge clk); #1;
    chk("ignored_start_idle", 32'(ifc.busy), 32'd0);

    // Asynchronous reset between edges in the middle of CALC.
    ifc.start = 1'b1; ifc.funct3 = 3'b001; ifc.rs1 = 32'h7FFFFFFF; ifc.rs2 = 32'h7FFFFFFF;
    @(posedge clk); #1;
    ifc.start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_busy",   32'(ifc.busy),  32'd0);
    chk("async_rst_stall",  32'(ifc.stall), 32'd0);
    chk("async_rst_done",   32'(ifc.done),  32'd0);
    chk("async_rst_result", ifc.result,     32'd0);
    $display("async reset mid-CALC: busy=%0d stall=%0d result=%h", ifc.busy, ifc.stall, ifc.result);
    #2;
    rst = 1'b0;
    @(posedge clk); #1;
    run_op(3'b110, 32'hFFFFFF9C, 32'd7, model(3'b110, 32'hFFFFFF9C, 32'd7), 34);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
